// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator operation controller.
// Holds op encodings, the controller state type and saturation-limit helpers.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Largest positive signed value of a w-bit word, in the low w bits.
  function automatic logic [31:0] satMax(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Most negative signed value of a w-bit word, in the low w bits.
  function automatic logic [31:0] satMin(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/calc_op_ctrl_if.sv
// calc_op_ctrl_if: request/result bundle between the calculator top and
// the operation controller. The master issues requests, the slave executes.
interface calc_op_ctrl_if #(parameter int W = 8) ();

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, ovf, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, ovf, err
  );

endinterface

// File: rtl/calc_mul_iter.sv
// calc_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands and clears the product; last is high
// during the cycle whose edge adds the final partial product.
module calc_mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplier_i,
  output logic [2*W-1:0] prod_o,
  output logic           last_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand_q;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q;

  assign last_o = run_q && (cnt_q == CW'(W - 1));
  assign prod_o = prod_q;

  // Load operands on start, then accumulate one shifted partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{W{1'b0}}, mcand_i};
      prod_q   <= '0;
      mplier_q <= mplier_i;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (last_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_op_ctrl.sv
// calc_op_ctrl: signed add/sub (and optional multiply) controller with
// operand registers, overflow detection and optional saturation.
// Build option: define CALC_CTRL_MUL_EN to enable the iterative multiplier;
// without it op 10 is reported as illegal.
module calc_op_ctrl
  import calc_pkg::*;
#(
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input logic          clk,
  input logic          rst,
  calc_op_ctrl_if.slave bus
);

  localparam logic [31:0]  MAX32   = satMax(W);
  localparam logic [31:0]  MIN32   = satMin(W);
  localparam logic [W-1:0] SAT_POS = MAX32[W-1:0];
  localparam logic [W-1:0] SAT_NEG = MIN32[W-1:0];

  state_e       state_q;
  logic [W-1:0] x_q;
  logic [W:0]   y_q;
  logic [1:0]   opr_q;
  logic [W-1:0] result_q;
  logic         ovf_q;
  logic         err_q;
  logic         done_q;

  logic [W:0]   bExt_d;
  logic [W:0]   sum_d;
  logic         sumOvf_d;
  logic [W-1:0] sumRes_d;
  logic         opIllegal_d;

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;

  assign bExt_d = {bus.b[W-1], bus.b};

  // W+1-bit add keeps the true sum so overflow and saturation sign are exact.
  always_comb begin
    sum_d    = {x_q[W-1], x_q} + y_q;
    sumOvf_d = sum_d[W] ^ sum_d[W-1];
    sumRes_d = sum_d[W-1:0];
    if ((SAT != 0) && sumOvf_d) begin
      sumRes_d = sum_d[W] ? SAT_NEG : SAT_POS;
    end
  end

`ifdef CALC_CTRL_MUL_EN
  logic [W-1:0]   xAbs_d;
  logic [W-1:0]   yAbs_d;
  logic           negProd_d;
  logic           mulStart_d;
  logic           mulLast_d;
  logic [2*W-1:0] prod_d;
  logic [2*W-1:0] prodS_d;
  logic           mulOvf_d;
  logic [W-1:0]   mulRes_d;

  assign opIllegal_d = (opr_q == OP_RSV);
  assign mulStart_d  = (state_q == S_LOAD) && (opr_q == OP_MUL);

  // Magnitudes feed the unsigned core; the sign is reapplied after the last bit.
  always_comb begin
    xAbs_d    = x_q[W-1] ? -x_q : x_q;
    yAbs_d    = y_q[W-1] ? -y_q[W-1:0] : y_q[W-1:0];
    negProd_d = x_q[W-1] ^ y_q[W-1];
    prodS_d   = negProd_d ? -prod_d : prod_d;
    mulOvf_d  = !((&prodS_d[2*W-1:W-1]) || !(|prodS_d[2*W-1:W-1]));
    mulRes_d  = prodS_d[W-1:0];
    if ((SAT != 0) && mulOvf_d) begin
      mulRes_d = negProd_d ? SAT_NEG : SAT_POS;
    end
  end

  calc_mul_iter #(.W(W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mulStart_d),
    .mcand_i  (xAbs_d),
    .mplier_i (yAbs_d),
    .prod_o   (prod_d),
    .last_o   (mulLast_d)
  );
`else
  assign opIllegal_d = (opr_q == OP_RSV) || (opr_q == OP_MUL);
`endif

  // Control FSM; result, ovf, err and done are registered on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      opr_q    <= OP_ADD;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            x_q     <= bus.a;
            opr_q   <= bus.op;
            y_q     <= (bus.op == OP_SUB) ? -bExt_d : bExt_d;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (opIllegal_d) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef CALC_CTRL_MUL_EN
          if (opr_q == OP_MUL) begin
            if (mulLast_d) begin
              state_q <= S_FIX;
            end
          end else
`endif
          begin
            result_q <= sumRes_d;
            ovf_q    <= sumOvf_d;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`ifdef CALC_CTRL_MUL_EN
        S_FIX: begin
          result_q <= mulRes_d;
          ovf_q    <= mulOvf_d;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_ctrl.sv
// tb_calc_op_ctrl: scoreboard bench driving one wrapping (SAT=0) and one
// saturating (SAT=1) controller with identical stimulus.
// Expected multiply behaviour follows CALC_CTRL_MUL_EN as the RTL does.
module tb_calc_op_ctrl;

  localparam int W      = 8;
  localparam int MULLAT = W + 2;
  localparam logic [W-1:0] POS_LIM = 8'h7F;
  localparam logic [W-1:0] NEG_LIM = 8'h80;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
    int           expDone;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  expT q0[$];
  expT q1[$];
  expT m0;
  expT m1;

  calc_op_ctrl_if #(.W(W)) bus0 ();
  calc_op_ctrl_if #(.W(W)) bus1 ();

  calc_op_ctrl #(.W(W), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  calc_op_ctrl #(.W(W), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time done pulses against the accepting edge
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic expT model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int sat);
    expT e;
    int  ai;
    int  bi;
    int  t;
    bit  legal;
    ai = int'($signed(a));
    bi = int'($signed(b));
    t = 0;
    legal = 1'b1;
    e.res = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = 2;
    e.expDone = 0;
    case (op)
      2'b00: t = ai + bi;
      2'b01: t = ai - bi;
`ifdef CALC_CTRL_MUL_EN
      2'b10: begin
        t = ai * bi;
        e.lat = MULLAT;
      end
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.ovf = (t > 127) || (t < -128);
      if (e.ovf && (sat != 0)) e.res = (t > 0) ? POS_LIM : NEG_LIM;
      else e.res = t[W-1:0];
    end
    return e;
  endfunction

  task automatic driveInputs(input logic s, input logic [1:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    bus0.start = s; bus0.op = op; bus0.a = a; bus0.b = b;
    bus1.start = s; bus1.op = op; bus1.a = a; bus1.b = b;
  endtask

  task automatic pushExpected(input logic [1:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int t0);
    expT e;
    e = model(op, a, b, 0);
    e.expDone = t0 + e.lat;
    q0.push_back(e);
    e = model(op, a, b, 1);
    e.expDone = t0 + e.lat;
    q1.push_back(e);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checkOutput("timeout pending results", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    driveInputs(1'b1, op, a, b);
    pushExpected(op, a, b, cycle + 1);
    @(negedge clk);
    driveInputs(1'b0, 2'($urandom), W'($urandom), W'($urandom));
    waitIdle();
  endtask

  // Scoreboard for the wrapping instance
  always @(negedge clk) begin
    if (bus0.done) begin
      if (q0.size() == 0) begin
        checkOutput("spurious done sat0", 32'(bus0.done), 32'd0);
      end else begin
        m0 = q0.pop_front();
        checkOutput("result sat0", 32'(bus0.result), 32'(m0.res));
        checkOutput("ovf sat0", 32'(bus0.ovf), 32'(m0.ovf));
        checkOutput("err sat0", 32'(bus0.err), 32'(m0.err));
        checkOutput("done cycle sat0", 32'(cycle), 32'(m0.expDone));
        checkOutput("busy at done sat0", 32'(bus0.busy), 32'd1);
      end
    end
  end

  // Scoreboard for the saturating instance
  always @(negedge clk) begin
    if (bus1.done) begin
      if (q1.size() == 0) begin
        checkOutput("spurious done sat1", 32'(bus1.done), 32'd0);
      end else begin
        m1 = q1.pop_front();
        checkOutput("result sat1", 32'(bus1.result), 32'(m1.res));
        checkOutput("ovf sat1", 32'(bus1.ovf), 32'(m1.ovf));
        checkOutput("err sat1", 32'(bus1.err), 32'(m1.err));
        checkOutput("done cycle sat1", 32'(cycle), 32'(m1.expDone));
        checkOutput("busy at done sat1", 32'(bus1.busy), 32'd1);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    int c0;
    int t1;
    int kAbort;
    logic [1:0] abortOp;
    expT e;

    driveInputs(1'b0, 2'b00, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset busy0", 32'(bus0.busy), 32'd0);
    checkOutput("reset done0", 32'(bus0.done), 32'd0);
    checkOutput("reset result0", 32'(bus0.result), 32'd0);
    checkOutput("reset ovf0", 32'(bus0.ovf), 32'd0);
    checkOutput("reset err0", 32'(bus0.err), 32'd0);
    checkOutput("reset busy1", 32'(bus1.busy), 32'd0);
    checkOutput("reset result1", 32'(bus1.result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(2'b00, 8'd100, 8'd50);
    applyStimulus(2'b01, 8'h80, 8'h01);
    applyStimulus(2'b01, 8'd5, 8'h80);
    applyStimulus(2'b01, 8'd20, 8'd7);
    applyStimulus(2'b00, 8'hFD, 8'hFB);
    applyStimulus(2'b00, 8'h80, 8'h80);
    applyStimulus(2'b10, 8'hF9, 8'd6);
    applyStimulus(2'b10, 8'd16, 8'd8);
    applyStimulus(2'b10, 8'h80, 8'hFF);
    applyStimulus(2'b10, 8'h80, 8'h80);
    applyStimulus(2'b10, 8'h00, 8'h7F);
    applyStimulus(2'b10, 8'hF5, 8'hF3);
    applyStimulus(2'b11, 8'd3, 8'd4);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end

    // start held high through a multiply: one done, then the next op in the first IDLE cycle
    @(negedge clk);
    driveInputs(1'b1, 2'b10, 8'hF9, 8'd6);
    c0 = cycle + 1;
    pushExpected(2'b10, 8'hF9, 8'd6, c0);
    e = model(2'b10, 8'hF9, 8'd6, 0);
    t1 = c0 + e.lat + 2;
    @(negedge clk);
    driveInputs(1'b1, 2'b00, 8'd3, 8'd4);
    pushExpected(2'b00, 8'd3, 8'd4, t1);
    while (cycle < t1) @(negedge clk);
    driveInputs(1'b0, 2'b00, W'($urandom), W'($urandom));
    checkOutput("busy after re-accept", 32'(bus0.busy), 32'd1);
    waitIdle();

    // reset in the middle of an operation aborts it without a done
`ifdef CALC_CTRL_MUL_EN
    abortOp = 2'b10;
    kAbort = 4;
`else
    abortOp = 2'b00;
    kAbort = 1;
`endif
    @(negedge clk);
    driveInputs(1'b1, abortOp, 8'd16, 8'd8);
    c0 = cycle + 1;
    @(negedge clk);
    driveInputs(1'b0, 2'b00, '0, '0);
    while (cycle < c0 + kAbort - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy0", 32'(bus0.busy), 32'd0);
    checkOutput("abort done0", 32'(bus0.done), 32'd0);
    checkOutput("abort busy1", 32'(bus1.busy), 32'd0);
    checkOutput("abort result0", 32'(bus0.result), 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    applyStimulus(2'b00, 8'd20, 8'd22);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
